// File: rtl/phy_pkg.sv
// Constants and state encoding shared by the PHY receive and transmit paths.
package phy_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;
  localparam logic [7:0] IDLE_7C  = 8'h7C;

  typedef enum logic [1:0] {
    HUNT,
    LOCK,
    ACTIVE
  } rx_state_t;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Line-side bit input and aligned byte output of the serial-to-parallel receiver.
interface serial_to_parallel_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (output data_in, input data_out, valid_out, active);
  modport slave  (input data_in, output data_out, valid_out, active);

endinterface

// File: rtl/serial_to_parallel.sv
// Comma-aligned deserialiser: locks after LOCK_COUNT commas and emits payload bytes.
// Registered outputs update on the edge sampling a byte's last bit; no backpressure, each byte is held 8 clk_16f edges.
module serial_to_parallel
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA      = COMMA_BC,
  parameter logic [7:0]  IDLE       = IDLE_7C,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                clk_16f,
  input  logic                reset,
  serial_to_parallel_if.slave rx
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);

  rx_state_t  state, state_nxt;
  logic [6:0] sh;          // the oldest line bit is never read, so only seven are kept
  logic [7:0] cand;
  logic [2:0] bit_cnt;
  logic [2:0] bc_cnt, bc_nxt, bc_inc;
  logic       boundary, is_comma, is_idle;
  logic       realign, slot_end, load_byte;

  assign cand     = {sh, rx.data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign is_comma = (cand == COMMA);
  assign is_idle  = (cand == IDLE);
  assign bc_inc   = (bc_cnt == 3'd7) ? bc_cnt : bc_cnt + 3'd1;

  always_ff @(posedge clk_16f) begin
    if (reset) begin
      state        <= HUNT;
      sh           <= '0;
      bit_cnt      <= '0;
      bc_cnt       <= '0;
      rx.data_out  <= '0;
      rx.valid_out <= 1'b0;
      rx.active    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sh      <= cand[6:0];
      bit_cnt <= realign ? 3'd0 : bit_cnt + 3'd1;
      bc_cnt  <= bc_nxt;
      if (state_nxt == ACTIVE) rx.active    <= 1'b1;
      if (slot_end)            rx.valid_out <= load_byte;
      if (load_byte)           rx.data_out  <= cand;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT: begin
        if (is_comma) state_nxt = (LOCK_N == 3'd1) ? ACTIVE : LOCK;
      end
      LOCK: begin
        if (boundary) begin
          if (!is_comma)             state_nxt = HUNT;
          else if (bc_inc == LOCK_N) state_nxt = ACTIVE;
        end
      end
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = HUNT;
    endcase
  end

  // A comma seen while hunting restarts byte framing so the next 8 bits form one byte.
  always_comb begin
    realign   = 1'b0;
    slot_end  = 1'b0;
    load_byte = 1'b0;
    bc_nxt    = bc_cnt;
    unique case (state)
      HUNT: begin
        if (is_comma) begin
          realign = 1'b1;
          bc_nxt  = 3'd1;
        end
      end
      LOCK: begin
        if (boundary) bc_nxt = is_comma ? bc_inc : 3'd0;
      end
      ACTIVE: begin
        if (boundary) begin
          slot_end  = 1'b1;
          load_byte = !is_comma && !is_idle;
          if (is_comma) bc_nxt = bc_inc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench: expected outputs are queued per edge as bytes are serialised and checked on that edge.
module tb_serial_to_parallel;
  import phy_pkg::*;

  typedef struct {
    int unsigned edge_n;
    string       tag;
    logic [7:0]  d;
    logic        v;
    logic        a;
  } exp_t;

  logic        clk_16f = 1'b0;
  logic        reset0;
  logic        reset1;
  logic        sel;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [7:0]  pd;
  logic        pv;
  logic        pa;

  always #5 clk_16f = ~clk_16f;

  serial_to_parallel_if bus0();
  serial_to_parallel_if bus1();

  serial_to_parallel #(.LOCK_COUNT(4)) dut0 (
    .clk_16f (clk_16f),
    .reset   (reset0),
    .rx      (bus0)
  );

  serial_to_parallel #(.LOCK_COUNT(1)) dut1 (
    .clk_16f (clk_16f),
    .reset   (reset1),
    .rx      (bus1)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %02h expected %02h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void expect_at(input int unsigned n, input string tag,
                                    input logic [7:0] d, input logic v, input logic a);
    exp_t e;
    e.edge_n = n;
    e.tag    = tag;
    e.d      = d;
    e.v      = v;
    e.a      = a;
    sb.push_back(e);
  endfunction

  // Edge counter plus checker: everything due at this edge is compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_16f);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
        e = sb.pop_front();
        check_val({e.tag, "/data"},   sel ? bus1.data_out : bus0.data_out, e.d);
        check_val({e.tag, "/valid"},  8'(sel ? bus1.valid_out : bus0.valid_out), 8'(e.v));
        check_val({e.tag, "/active"}, 8'(sel ? bus1.active : bus0.active), 8'(e.a));
      end
    end
  end

  task automatic set_rst(input logic v);
    if (sel) reset1 = v;
    else     reset0 = v;
  endtask

  task automatic drive_bit(input logic b);
    bus0.data_in = b;
    bus1.data_in = b;
    @(negedge clk_16f);
  endtask

  // Serialise one byte; previous outputs must hold through edge 7, new outputs appear on edge 8.
  task automatic send(input string tag, input logic [7:0] b,
                      input logic [7:0] d, input logic v, input logic a);
    expect_at(cyc + 7, {tag, ":hold"}, pd, pv, pa);
    expect_at(cyc + 8, tag, d, v, a);
    for (int i = 7; i >= 0; i--) drive_bit(b[i]);
    pd = d;
    pv = v;
    pa = a;
  endtask

  task automatic pulse_reset();
    expect_at(cyc + 2, "reset", 8'h00, 1'b0, 1'b0);
    set_rst(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    set_rst(1'b0);
    pd = 8'h00;
    pv = 1'b0;
    pa = 1'b0;
  endtask

  // Serialise a byte with reset asserted on its k-th bit (1-based); the rest of the byte is discarded.
  task automatic reset_in_byte(input string tag, input logic [7:0] b, input int k);
    expect_at(cyc + 32'(k) - 1, {tag, ":before"}, pd, pv, pa);
    expect_at(cyc + 32'(k), tag, 8'h00, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      set_rst((7 - i) == (k - 1));
      drive_bit(b[i]);
    end
    set_rst(1'b0);
    pd = 8'h00;
    pv = 1'b0;
    pa = 1'b0;
  endtask

  initial begin
    reset0       = 1'b1;
    reset1       = 1'b1;
    sel          = 1'b0;
    bus0.data_in = 1'b0;
    bus1.data_in = 1'b0;
    pd           = 8'h00;
    pv           = 1'b0;
    pa           = 1'b0;
    @(negedge clk_16f);

    // Basic lock, filler suppression, reset mid-payload and re-lock
    pulse_reset();
    send("bl_bc1", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bl_bc2", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bl_bc3", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bl_bc4", COMMA_BC, 8'h00, 1'b0, 1'b1);
    send("bl_5a",  8'h5A,    8'h5A, 1'b1, 1'b1);
    send("fs_7c",  IDLE_7C,  8'h5A, 1'b0, 1'b1);
    send("fs_bc",  COMMA_BC, 8'h5A, 1'b0, 1'b1);
    send("fs_99",  8'h99,    8'h99, 1'b1, 1'b1);
    reset_in_byte("rm_rst", 8'hC3, 4);
    send("rm_bc1", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("rm_bc2", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("rm_bc3", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("rm_bc4", COMMA_BC, 8'h00, 1'b0, 1'b1);
    send("rm_6e",  8'h6E,    8'h6E, 1'b1, 1'b1);

    // Misaligned start
    pulse_reset();
    repeat (3) drive_bit(1'($urandom_range(0, 1)));
    send("ma_bc1", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("ma_bc2", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("ma_bc3", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("ma_bc4", COMMA_BC, 8'h00, 1'b0, 1'b1);
    send("ma_11",  8'h11,    8'h11, 1'b1, 1'b1);
    send("ma_22",  8'h22,    8'h22, 1'b1, 1'b1);

    // Broken training: the idle byte restarts the comma count
    pulse_reset();
    send("bt_bc1", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bt_bc2", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bt_7c",  IDLE_7C,  8'h00, 1'b0, 1'b0);
    send("bt_bc3", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bt_bc4", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bt_bc5", COMMA_BC, 8'h00, 1'b0, 1'b0);
    send("bt_bc6", COMMA_BC, 8'h00, 1'b0, 1'b1);
    send("bt_33",  8'h33,    8'h33, 1'b1, 1'b1);

    // LOCK_COUNT = 1 variant, then reset landing exactly on a byte boundary
    sel = 1'b1;
    pulse_reset();
    send("lc1_bc", COMMA_BC, 8'h00, 1'b0, 1'b1);
    send("lc1_a5", 8'hA5,    8'hA5, 1'b1, 1'b1);
    reset_in_byte("lc1_rst_bnd", 8'h3C, 8);
    repeat (4) drive_bit(1'b0);

    check_val("sb_drain", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion by %0t, expected finish", $time);
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Serial-to-parallel receiver at the front of the PHY receive path. It deserialises a 1-bit line stream at `clk_16f` and hunts for byte alignment using the comma character. It declares lock after consecutive commas, then emits aligned payload bytes with a valid flag. Its byte output feeds the lane demultiplexer stage, which samples at `clk_2f`; each output byte is held stable for 8 `clk_16f` cycles.

## Interface
- `COMMA`, default 8'hBC: alignment/training character.
- `IDLE`, default 8'h7C: idle filler; never reported as valid data.
- `LOCK_COUNT`, default 4: consecutive aligned commas required to assert `active`. Legal range 1..7.
- `clk_16f`  in  1: serial bit clock; the only clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `data_in`  in  1: serial line bit, MSB of each byte first.
- `data_out`  out  8: last aligned payload byte.
- `valid_out`  out  1: `data_out` holds a payload byte received in the current byte slot.
- `active`  out  1: receiver locked; remains set until `reset`.

## Operation
- Shift register `sh[7:0]` shifts on every edge: `sh <= {sh[6:0], data_in}`.
- Candidate byte `cand = {sh[6:0], data_in}` is combinational and evaluated at the edge.
- Bit counter `bit_cnt[2:0]` increments modulo 8.
- A byte boundary is any edge with `bit_cnt == 7`.
- Comma counter `bc_cnt[2:0]`.

FSM states:
- **HUNT** (reset state):
  - `cand` is compared every edge.
  - On `cand == COMMA`: `bit_cnt <= 0` (the next 8 bits form a byte), `bc_cnt <= 1`.
  - Go to ACTIVE if `LOCK_COUNT == 1`, else to LOCK.
- **LOCK**: compares `cand` only at byte boundaries.
  - `COMMA`: `bc_cnt <= bc_cnt + 1`. When the new value equals `LOCK_COUNT`, go to ACTIVE and set `active <= 1`.
  - Any other byte, including `IDLE`: `bc_cnt <= 0` and return to HUNT. HUNT then compares sliding windows from the next edge.
- **ACTIVE**: at each byte boundary:
  - `cand` not `COMMA` and not `IDLE`: `data_out <= cand`, `valid_out <= 1`.
  - `COMMA` or `IDLE`: `valid_out <= 0` and `data_out` holds.
  - ACTIVE never drops lock; only `reset` leaves it. `bc_cnt` saturates.
- Outside ACTIVE: `valid_out = 0` and `data_out` holds its reset value.

Reset behaviour:
- On `reset` at an edge: `sh = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state HUNT, `data_out = 8'h00`, `valid_out = 0`, `active = 0`.
- Reset applied mid-byte or while in ACTIVE discards the partial byte. A full re-lock (`LOCK_COUNT` commas) is then required.

## Timing
- Outputs are registered.
- Latency: the last bit of a byte is sampled at edge N. `data_out`/`valid_out` reflect that byte from edge N.
- Outputs hold for exactly 8 edges, until the next boundary at N+8.
- `active` rises at the edge sampling the last bit of the `LOCK_COUNT`-th comma.
- The first possible `valid_out` is 8 edges after `active` rises.
- In HUNT, a comma window is recognised on the same edge its last bit arrives. No alignment slip penalty applies.
- Reset asserted together with a byte boundary: reset wins; no output update.
- `reset` is sampled every edge. Deasserting it means HUNT begins comparing at the next edge.

## Structure
- Shared package `phy_pkg` holds:
  - `COMMA_BC` (8'hBC) and `IDLE_7C` (8'h7C) constants, also used by the transmit-side parallel-to-serial block.
  - The `rx_state_t` enum: HUNT, LOCK, ACTIVE.
- Single module; FSM, shifter and counters share one always block plus the `cand` assign.
- No sub-module. The design is too small to justify splitting out the shifter.

## Test plan
- **Basic lock:** reset 2 cycles, then serialise BC,BC,BC,BC,0x5A MSB-first. Required: `active` rises on the 32nd bit edge after reset release; `data_out = 8'h5A` with `valid_out = 1` at the 40th edge, held 8 edges.
- **Misaligned start:** 3 random bits, then BC×4, 0x11, 0x22. Required: lock despite the offset; 0x11 then 0x22 appear on consecutive byte boundaries.
- **Broken training:** BC,BC,0x7C,BC×4,0x33. Required: `active` stays 0 after the 7C; the count restarts; lock occurs after the last 4 BCs; then 0x33 is reported.
- **Filler suppression in ACTIVE:** after lock, send 0x7C, 0xBC, 0x99. Required: `valid_out = 0` for two slots, `data_out` keeps its prior value, then 0x99 with `valid_out = 1`.
- **Reset mid-operation:** assert `reset` on bit 4 of a payload byte in ACTIVE. Required: next edge `active = 0`, `valid_out = 0`, `data_out = 8'h00`; re-lock needs 4 fresh BCs.
- **Parameter variant** `LOCK_COUNT = 1`: a single BC asserts `active` immediately; the next byte 0xA5 is reported valid.
